// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake and ALU-facing bus of alu_issue_ctrl.
// slave is the issue controller; master is its environment (decode stage + ALU).
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_taken;
    logic             rsp_illegal;

    modport slave (
        input  req_valid, alu_op, funct3, funct7_5, op_a, op_b,
               alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_control,
               rsp_valid, rsp_result, rsp_taken, rsp_illegal
    );

    modport master (
        output req_valid, alu_op, funct3, funct7_5, op_a, op_b,
               alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_control,
               rsp_valid, rsp_result, rsp_taken, rsp_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Transaction wrapper around a combinational ALU: accept -> one execute cycle
// -> registered response, with branch resolution and illegal-op reporting.
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.slave   bus
);
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_ILL = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       is_br;
        logic       is_bne;
        logic       illegal;
    } dec_t;

    state_t           state;
    dec_t             dec;
    dec_t             dec_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_taken_q;
    logic             rsp_illegal_q;

    // Anything not explicitly matched falls through as illegal.
    always_comb begin
        dec.ctrl    = CTL_ILL;
        dec.is_br   = 1'b0;
        dec.is_bne  = 1'b0;
        dec.illegal = 1'b1;
        unique case (bus.alu_op)
            2'b00: begin
                dec.ctrl    = CTL_ADD;
                dec.illegal = 1'b0;
            end
            2'b01: begin
                if (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) begin
                    dec.ctrl    = CTL_SUB;
                    dec.is_br   = 1'b1;
                    dec.is_bne  = bus.funct3[0];
                    dec.illegal = 1'b0;
                end
            end
            2'b10: begin
                unique case (bus.funct3)
                    3'b000: begin
                        dec.ctrl    = bus.funct7_5 ? CTL_SUB : CTL_ADD;
                        dec.illegal = 1'b0;
                    end
                    3'b111: begin
                        dec.ctrl    = CTL_AND;
                        dec.illegal = 1'b0;
                    end
                    3'b110: begin
                        dec.ctrl    = CTL_OR;
                        dec.illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            dec_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q         <= bus.op_a;
                        b_q         <= bus.op_b;
                        dec_q       <= dec;
                        req_ready_q <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // BEQ takes on zero, BNE on non-zero: is_bne flips the sense.
                    rsp_result_q  <= dec_q.illegal ? '0 : bus.alu_result;
                    rsp_taken_q   <= !dec_q.illegal && dec_q.is_br &&
                                     (dec_q.is_bne ^ bus.alu_zero);
                    rsp_illegal_q <= dec_q.illegal;
                    rsp_valid_q   <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_control = dec_q.ctrl;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_taken   = rsp_taken_q;
    assign bus.rsp_illegal = rsp_illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached to the bus.
module tb_alu_issue_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: unknown codes produce junk so illegal responses must mask it.
    always_comb begin
        case (bus.alu_control)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = 32'hDEAD_BEEF;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.alu_op    = op;
        bus.funct3    = f3;
        bus.funct7_5  = f7;
        bus.op_a      = a;
        bus.op_b      = b;
    endtask

    task automatic junk_req();
        bus.req_valid = 1'b0;
        bus.alu_op    = 2'b11;
        bus.funct3    = 3'b101;
        bus.funct7_5  = 1'b1;
        bus.op_a      = 32'hA5A5_A5A5;
        bus.op_b      = 32'h5A5A_5A5A;
    endtask

    // Full transaction with immediate response acceptance; called from IDLE.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_ctl, input logic [31:0] exp_res,
                         input logic exp_tk, input logic exp_ill);
        drive_req(op, f3, f7, a, b);
        tick();
        junk_req();
        chk({tag, " exec req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " exec alu_control"}, 32'(bus.alu_control), 32'(exp_ctl));
        chk({tag, " exec alu_a"}, bus.alu_a, a);
        chk({tag, " exec alu_b"}, bus.alu_b, b);
        tick();
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, " rsp_result"}, bus.rsp_result, exp_res);
        chk({tag, " rsp_taken"}, 32'(bus.rsp_taken), 32'(exp_tk));
        chk({tag, " rsp_illegal"}, 32'(bus.rsp_illegal), 32'(exp_ill));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, " done rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " done req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " rsp_result"}, bus.rsp_result, 32'd0);
        chk({tag, " rsp_taken"}, 32'(bus.rsp_taken), 32'd0);
        chk({tag, " rsp_illegal"}, 32'(bus.rsp_illegal), 32'd0);
        chk({tag, " alu_a"}, bus.alu_a, 32'd0);
        chk({tag, " alu_b"}, bus.alu_b, 32'd0);
        chk({tag, " alu_control"}, 32'(bus.alu_control), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        junk_req();
        bus.rsp_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        reset = 1'b1;
        tick();
        chk("idle req_ready", 32'(bus.req_ready), 32'd1);

        do_op("add",      2'b10, 3'b000, 1'b0, 32'h5,    32'h3,    4'b0010, 32'h8,         1'b0, 1'b0);
        do_op("beq_tk",   2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234, 4'b0110, 32'h0,         1'b1, 1'b0);
        do_op("bne_nt",   2'b01, 3'b001, 1'b0, 32'h1234, 32'h1234, 4'b0110, 32'h0,         1'b0, 1'b0);
        do_op("bne_tk",   2'b01, 3'b001, 1'b0, 32'h1234, 32'h1235, 4'b0110, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("beq_nt",   2'b01, 3'b000, 1'b0, 32'h1234, 32'h1235, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("ill_r010", 2'b10, 3'b010, 1'b0, 32'h7,    32'h9,    4'b1111, 32'h0,         1'b0, 1'b1);
        do_op("ill_op11", 2'b11, 3'b000, 1'b0, 32'h7,    32'h9,    4'b1111, 32'h0,         1'b0, 1'b1);
        do_op("ill_br",   2'b01, 3'b100, 1'b0, 32'h5,    32'h5,    4'b1111, 32'h0,         1'b0, 1'b1);
        do_op("sub",      2'b10, 3'b000, 1'b1, 32'hA,    32'h3,    4'b0110, 32'h7,         1'b0, 1'b0);
        do_op("or",       2'b10, 3'b110, 1'b0, 32'hF0,   32'h0F,   4'b0001, 32'hFF,        1'b0, 1'b0);
        do_op("ldst",     2'b00, 3'b111, 1'b1, 32'h100,  32'h20,   4'b0010, 32'h120,       1'b0, 1'b0);
        do_op("wrap_sub", 2'b10, 3'b000, 1'b1, 32'h0,    32'h1,    4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("wrap_add", 2'b10, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h2, 4'b0010, 32'h1,       1'b0, 1'b0);

        // Backpressure: response held 5 cycles while a second request waits.
        drive_req(2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tick();
        chk("bp exec alu_control", 32'(bus.alu_control), 32'h0);
        drive_req(2'b00, 3'b000, 1'b0, 32'h7, 32'h9);
        tick();
        chk("bp rsp_result", bus.rsp_result, 32'hF000_F000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp hold rsp_result", bus.rsp_result, 32'hF000_F000);
            chk("bp hold req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp hold alu_a", bus.alu_a, 32'hF0F0_F0F0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp hs rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp hs req_ready", 32'(bus.req_ready), 32'd1);
        tick();
        junk_req();
        chk("bp2 exec req_ready", 32'(bus.req_ready), 32'd0);
        chk("bp2 exec alu_a", bus.alu_a, 32'h7);
        chk("bp2 exec alu_control", 32'(bus.alu_control), 32'h2);
        chk("bp2 exec rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("bp2 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp2 rsp_result", bus.rsp_result, 32'h10);
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp2 done req_ready", 32'(bus.req_ready), 32'd1);

        // Reset during EXEC aborts the transaction.
        drive_req(2'b10, 3'b000, 1'b0, 32'h11, 32'h22);
        tick();
        junk_req();
        chk("rst exec alu_a", bus.alu_a, 32'h11);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("post rst req_ready", 32'(bus.req_ready), 32'd1);
        end
        do_op("after_rst", 2'b10, 3'b000, 1'b0, 32'h11, 32'h22, 4'b0010, 32'h33, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
